// File: rtl/winograd_output_transform_unit.sv
// Winograd F(4x4,3x3) output transform Y = A^T * M * A, one column per cycle then one row per cycle.
// Optional build macro WINOGRAD_OTU_ACCUM_EN adds an accum input that sums results into tile_out.
module winograd_output_transform_unit (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
`ifdef WINOGRAD_OTU_ACCUM_EN
   input  logic                    accum,
`endif
   input  logic [0:5][0:5][31:0]   tile_in,
   output logic [0:3][0:3][31:0]   tile_out,
   output logic                    busy,
   output logic                    transform_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PASS1 = 2'd1;
   localparam logic [1:0] S_PASS2 = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                state_r;
   logic [2:0]                idx_r;
   logic [0:5][0:5][31:0]     m_r;
   logic [0:3][0:5][31:0]     t_r;
   logic [0:5][31:0]          col_s;
   logic [0:3][31:0]          pass1_s;
   logic [0:3][31:0]          pass2_s;
`ifdef WINOGRAD_OTU_ACCUM_EN
   logic                      accum_r;
`endif

   // A^T applied to a 6-vector; scaling by 2/4/8 is done with shifts, all sums wrap mod 2^32
   function automatic logic [0:3][31:0] at_mul(input logic [0:5][31:0] v);
      logic [0:3][31:0] r;
      r[0] = v[0] + v[1] + v[2] + v[3] + v[4];
      r[1] = v[1] - v[2] + (v[3] << 32'd1) - (v[4] << 32'd1);
      r[2] = v[1] + v[2] + (v[3] << 32'd2) + (v[4] << 32'd2);
      r[3] = v[1] - v[2] + (v[3] << 32'd3) - (v[4] << 32'd3) + v[5];
      return r;
   endfunction

   // gather the M column addressed by idx for the first pass
   always_comb begin
      col_s = '0;
      for (int k = 0; k < 6; k++) begin
         col_s[k] = m_r[k][idx_r];
      end
   end

   assign pass1_s = at_mul(col_s);
   // row idx of T times A equals A^T applied to that row
   assign pass2_s = at_mul(t_r[idx_r[1:0]]);
   assign busy    = (state_r != S_IDLE);

   // control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= S_IDLE;
         idx_r          <= 3'd0;
         m_r            <= '0;
         t_r            <= '0;
         tile_out       <= '0;
         transform_done <= 1'b0;
`ifdef WINOGRAD_OTU_ACCUM_EN
         accum_r        <= 1'b0;
`endif
      end else begin
         case (state_r)
            S_IDLE: begin
               transform_done <= 1'b0;
               if (start) begin
                  m_r     <= tile_in;
                  idx_r   <= 3'd0;
                  state_r <= S_PASS1;
`ifdef WINOGRAD_OTU_ACCUM_EN
                  accum_r <= accum;
`endif
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_PASS1: begin
               for (int i = 0; i < 4; i++) begin
                  t_r[i][idx_r] <= pass1_s[i];
               end
               if (idx_r == 3'd5) begin
                  idx_r   <= 3'd0;
                  state_r <= S_PASS2;
               end else begin
                  idx_r   <= idx_r + 3'd1;
               end
            end
            S_PASS2: begin
               for (int j = 0; j < 4; j++) begin
`ifdef WINOGRAD_OTU_ACCUM_EN
                  if (accum_r) begin
                     tile_out[idx_r[1:0]][j] <= tile_out[idx_r[1:0]][j] + pass2_s[j];
                  end else begin
                     tile_out[idx_r[1:0]][j] <= pass2_s[j];
                  end
`else
                  tile_out[idx_r[1:0]][j] <= pass2_s[j];
`endif
               end
               if (idx_r == 3'd3) begin
                  idx_r   <= 3'd0;
                  state_r <= S_DONE;
               end else begin
                  idx_r   <= idx_r + 3'd1;
               end
            end
            S_DONE: begin
               transform_done <= 1'b1;
               state_r        <= S_IDLE;
            end
            default: begin
               state_r        <= S_IDLE;
               idx_r          <= 3'd0;
               transform_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_winograd_output_transform_unit.sv
// Scoreboard bench for winograd_output_transform_unit: expected tiles from a plain matrix model.
module tb_winograd_output_transform_unit;

   typedef logic [0:5][0:5][31:0] min_t;
   typedef logic [0:3][0:3][31:0] yout_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b1;
   logic  start = 1'b0;
   logic  accum_drv = 1'b0;
   min_t  tile_in = '0;
   yout_t tile_out;
   logic  busy;
   logic  transform_done;

   int    checks = 0;
   int    errors = 0;
   int    cyc_cnt = 0;
   int    done_cyc = 0;
   yout_t last_exp = '0;
   yout_t sb_q[$];

   winograd_output_transform_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
`ifdef WINOGRAD_OTU_ACCUM_EN
      .accum          (accum_drv),
`endif
      .tile_in        (tile_in),
      .tile_out       (tile_out),
      .busy           (busy),
      .transform_done (transform_done)
   );

   always #5 clk = ~clk;

   // free-running cycle counter for latency / spacing checks
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic yout_t model(input min_t m);
      int at [4][6] = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
                        '{0, 1, 1, 4, 4, 0},  '{0, 1, -1, 8, -8, 1}};
      int t [4][6];
      int s;
      yout_t y;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 6; c++) begin
            s = 0;
            for (int k = 0; k < 6; k++) s += at[i][k] * int'(m[k][c]);
            t[i][c] = s;
         end
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 6; k++) s += t[i][k] * at[j][k];
            y[i][j] = s;
         end
      end
      return y;
   endfunction

   task automatic run_tile(input min_t m, input bit acc, input bit poke);
      yout_t e;
      yout_t got_tile;
      int    cyc;
      bit    got;
      e = model(m);
      if (acc) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) e[i][j] = last_exp[i][j] + e[i][j];
      end
      sb_q.push_back(e);
      last_exp = e;
      @(negedge clk);
      tile_in   = m;
      accum_drv = acc;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) tile_in[i][j] = $urandom;
      check_val("busy_after_start", {31'd0, busy}, 32'd1);
      check_val("done_clear", {31'd0, transform_done}, 32'd0);
      cyc = 0;
      got = 1'b0;
      while (cyc < 40 && !got) begin
         @(negedge clk);
         start = poke && (cyc == 2 || cyc == 6);
         @(posedge clk);
         #1;
         cyc++;
         if (transform_done) got = 1'b1;
      end
      start = 1'b0;
      check_val("done_latency", got ? cyc : 0, 32'd11);
      done_cyc = cyc_cnt;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         got_tile = sb_q.pop_front();
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               check_val($sformatf("y[%0d][%0d]", i, j), tile_out[i][j], got_tile[i][j]);
      end
   endtask

   initial begin
      min_t m;
      int   d1;
      bit   seen;
      #3 rst_n = 1'b0;
      #20;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) check_val("reset_out", tile_out[i][j], 32'd0);
      check_val("reset_busy", {31'd0, busy}, 32'd0);
      check_val("reset_done", {31'd0, transform_done}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // all ones
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) m[i][j] = 32'd1;
      run_tile(m, 1'b0, 1'b0);
      check_val("ones_y00", tile_out[0][0], 32'd25);
      check_val("ones_y02", tile_out[0][2], 32'd50);
      check_val("ones_y22", tile_out[2][2], 32'd100);
      check_val("ones_y33", tile_out[3][3], 32'd1);
      check_val("ones_y13", tile_out[1][3], 32'd0);

      // deltas
      m = '0; m[0][0] = 32'd7;
      run_tile(m, 1'b0, 1'b0);
      check_val("delta_y00", tile_out[0][0], 32'd7);
      m = '0; m[5][5] = 32'd3;
      run_tile(m, 1'b0, 1'b0);
      check_val("delta_y33", tile_out[3][3], 32'd3);
      check_val("delta_y00b", tile_out[0][0], 32'd0);

      // wrap-around
      m = '0; m[3][3] = 32'h2000_0000;
      run_tile(m, 1'b0, 1'b0);
      check_val("wrap_y00", tile_out[0][0], 32'h2000_0000);
      check_val("wrap_y11", tile_out[1][1], 32'h8000_0000);
      check_val("wrap_y33", tile_out[3][3], 32'd0);

      // ignored starts mid-tile, then a back-to-back pair
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) m[i][j] = $urandom;
      run_tile(m, 1'b0, 1'b1);
      d1 = done_cyc;
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) m[i][j] = $urandom;
      run_tile(m, 1'b0, 1'b0);
      check_val("b2b_spacing", done_cyc - d1, 32'd12);

      // reset while in the second pass, idx=2
      for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) m[i][j] = 32'd1;
      @(negedge clk);
      tile_in = m;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) check_val("midrst_out", tile_out[i][j], 32'd0);
      check_val("midrst_busy", {31'd0, busy}, 32'd0);
      check_val("midrst_done", {31'd0, transform_done}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      last_exp = '0;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1 if (transform_done) seen = 1'b1;
      end
      check_val("midrst_nodone", {31'd0, seen}, 32'd0);
      run_tile(m, 1'b0, 1'b0);
      check_val("postrst_y00", tile_out[0][0], 32'd25);
      check_val("postrst_y22", tile_out[2][2], 32'd100);

`ifdef WINOGRAD_OTU_ACCUM_EN
      run_tile(m, 1'b0, 1'b0);
      run_tile(m, 1'b1, 1'b0);
      check_val("acc_y00", tile_out[0][0], 32'd50);
      check_val("acc_y22", tile_out[2][2], 32'd200);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/winograd_output_transform_unit.md
WINOGRAD_OUTPUT_TRANSFORM_UNIT -- requirements
Module: winograd_output_transform_unit

Interface
REQ-001 SHALL have no parameters; widths are fixed at 32-bit elements, 6x6 input tile and 4x4 output tile.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in S_IDLE.
REQ-005 tile_in  input  32 x [0:5][0:5]  elementwise-product tile M, signed two's complement.
REQ-006 tile_out  output  32 x [0:3][0:3]  registered result Y = A^T * M * A.
REQ-007 busy  output  1  combinational; high whenever state != S_IDLE.
REQ-008 transform_done  output  1  registered; one-cycle completion pulse.

Function
REQ-009 SHALL use A^T rows: [1,1,1,1,1,0], [0,1,-1,2,-2,0], [0,1,1,4,4,0], [0,1,-1,8,-8,1] (F(4x4,3x3)).
REQ-010 SHALL use states S_IDLE, S_PASS1, S_PASS2 and S_DONE; illegal encodings SHALL return to S_IDLE.
REQ-011 In S_IDLE, start=1 at edge N SHALL latch tile_in into internal M, clear idx to 0, and enter S_PASS1; tile_in is don't-care afterwards.
REQ-012 S_PASS1, idx 0..5 (edges N+1..N+6): T[0..3][idx] <= A^T * column idx of M; at idx=5, idx SHALL clear to 0 and the state SHALL move to S_PASS2.
REQ-013 S_PASS2, idx 0..3 (edges N+7..N+10): tile_out[idx][0..3] <= row idx of T * A; at idx=3, idx SHALL clear to 0 and the state SHALL move to S_DONE.
REQ-014 S_DONE (edge N+11): transform_done <= 1, then S_IDLE; transform_done SHALL be high exactly one cycle, between edges N+11 and N+12.
REQ-015 S_IDLE SHALL drive transform_done <= 0; start=1 at edge N+12 SHALL begin a new tile, giving back-to-back throughput of one tile per 12 cycles.
REQ-016 start SHALL be ignored in any state other than S_IDLE; in-flight M SHALL NOT be disturbed.
REQ-017 All arithmetic SHALL be 32-bit signed with wrap-around modulo 2^32; multiplies by 2/4/8 SHALL be shifts; there is no saturation.
REQ-018 tile_out SHALL hold its value from edge N+10 until rows are overwritten in the next S_PASS2.
REQ-019 During S_PASS2, tile_out rows SHALL update one per cycle; a partial tile is visible while busy=1.

Reset
REQ-020 rst_n low SHALL immediately force S_IDLE, idx=0, transform_done=0, busy=0, and clear M, T and tile_out to 0.
REQ-021 Reset mid-pass SHALL abort the tile without producing a done pulse; the first start after rst_n deasserts SHALL behave per REQ-011.

Configuration
REQ-022 Macro WINOGRAD_OTU_ACCUM_EN SHALL control accumulation of results across tiles.
REQ-023 With WINOGRAD_OTU_ACCUM_EN defined:
- An extra input port accum (1 bit) SHALL exist and SHALL be latched with start.
- If the latched accum is 1, S_PASS2 SHALL write tile_out[idx][j] <= tile_out[idx][j] + result (32-bit wrap); otherwise it SHALL overwrite.
REQ-024 Without WINOGRAD_OTU_ACCUM_EN, the accum port SHALL be absent and S_PASS2 SHALL always overwrite.

Verification
REQ-025 All M=1: Y[i][j] = r_i * r_j with r = [5,0,10,1]. Check Y[0][0]=25, Y[0][2]=50, Y[2][2]=100, Y[3][3]=1, Y[1][x]=0; done pulses once, 11 cycles after the start edge.
REQ-026 Delta inputs: M[0][0]=7, others 0 -> Y[0][0]=7, others 0. M[5][5]=3, others 0 -> Y[3][3]=3, others 0.
REQ-027 Wrap check: M[3][3]=32'h2000_0000 -> Y[0][0]=32'h2000_0000, Y[1][1]=32'h8000_0000, Y[3][3]=0.
REQ-028 Protocol check:
- Pulse start at cycles 3 and 7 of a busy tile -> ignored; the output matches a single run.
- Start at the cycle after done -> second tile completes 12 cycles after the first.
REQ-029 Reset check: assert rst_n low in S_PASS2 idx=2 -> outputs zero immediately, no done pulse; a subsequent all-ones tile is correct per REQ-025.
REQ-030 With WINOGRAD_OTU_ACCUM_EN: all-ones tile with accum=0, then the same tile with accum=1 -> Y[0][0]=50, Y[2][2]=200.
